alu_seq_control: RTL and testbench

ALU_SEQ_CONTROL -- requirements
Module: alu_seq_control

---
 rtl/alu_seq_control.sv | 196 +++++++++++++++++++
 tb/tb_alu_seq_control.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_control.sv
// ALU control decoder with a valid/ready handshake and an optional shift-add multiplier.
// Defining ALU_SEQ_MULDIV_EN enables the multi-cycle MUL path (fun7 0000001, fun3 000).
module alu_seq_control #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [6:0]        fun7,
  input  logic [2:0]        fun3,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] control_out,
  output logic [XLEN-1:0]   mul_result,
  output logic              illegal
);

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_SLL  = 4'b0011;
  localparam logic [3:0] C_SLT  = 4'b0100;
  localparam logic [3:0] C_SLTU = 4'b0101;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_XOR  = 4'b0111;
  localparam logic [3:0] C_SRL  = 4'b1000;
  localparam logic [3:0] C_SRA  = 4'b1001;
  localparam logic [3:0] C_ILL  = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;
  logic       r_in_ready;
  logic       r_out_valid;
  logic [3:0] r_ctrl;
  logic       r_illegal;

  logic [3:0] w_dec_ctrl;
  logic       w_dec_illegal;

`ifdef ALU_SEQ_MULDIV_EN
  localparam logic [3:0] C_MUL = 4'b1010;
  localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;

  logic             w_dec_mul;
  logic [XLEN-1:0]  r_a;
  logic [XLEN-1:0]  r_b;
  logic [XLEN-1:0]  r_acc;
  logic [XLEN-1:0]  r_mul_result;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  w_acc_next;

  // r_a is pre-shifted each cycle, so it always equals op_a << counter (truncated)
  assign w_acc_next = r_acc + (r_b[0] ? r_a : '0);
  assign mul_result = r_mul_result;
`else
  logic w_unused_ops;

  assign w_unused_ops = ^{op_a, op_b};
  assign mul_result   = '0;
`endif

  always_comb begin
    w_dec_ctrl    = C_ILL;
    w_dec_illegal = 1'b1;
`ifdef ALU_SEQ_MULDIV_EN
    w_dec_mul     = 1'b0;
`endif
    case (alu_op)
      2'b00: begin
        w_dec_ctrl    = C_ADD;
        w_dec_illegal = 1'b0;
      end
      2'b01: begin
        w_dec_ctrl    = C_SUB;
        w_dec_illegal = 1'b0;
      end
      2'b10: begin
        if (fun7 == 7'b0000000) begin
          w_dec_illegal = 1'b0;
          case (fun3)
            3'b000:  w_dec_ctrl = C_ADD;
            3'b001:  w_dec_ctrl = C_SLL;
            3'b010:  w_dec_ctrl = C_SLT;
            3'b011:  w_dec_ctrl = C_SLTU;
            3'b100:  w_dec_ctrl = C_XOR;
            3'b101:  w_dec_ctrl = C_SRL;
            3'b110:  w_dec_ctrl = C_OR;
            default: w_dec_ctrl = C_AND;
          endcase
        end else if (fun7 == 7'b0100000 && fun3 == 3'b000) begin
          w_dec_ctrl    = C_SUB;
          w_dec_illegal = 1'b0;
        end else if (fun7 == 7'b0100000 && fun3 == 3'b101) begin
          w_dec_ctrl    = C_SRA;
          w_dec_illegal = 1'b0;
        end
`ifdef ALU_SEQ_MULDIV_EN
        else if (fun7 == 7'b0000001 && fun3 == 3'b000) begin
          w_dec_ctrl    = C_MUL;
          w_dec_illegal = 1'b0;
          w_dec_mul     = 1'b1;
        end
`endif
      end
      default: begin
        w_dec_ctrl    = C_ILL;
        w_dec_illegal = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_ctrl      <= 4'b0000;
      r_illegal   <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
      r_a          <= '0;
      r_b          <= '0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_mul_result <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_in_ready <= 1'b0;
            r_ctrl     <= w_dec_ctrl;
            r_illegal  <= w_dec_illegal;
`ifdef ALU_SEQ_MULDIV_EN
            if (w_dec_mul) begin
              r_state <= S_MUL;
              r_a     <= op_a;
              r_b     <= op_b;
              r_acc   <= '0;
              r_cnt   <= '0;
            end else begin
              r_state      <= S_DONE;
              r_out_valid  <= 1'b1;
              r_mul_result <= '0;
            end
`else
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
`endif
          end
        end
`ifdef ALU_SEQ_MULDIV_EN
        S_MUL: begin
          r_acc <= w_acc_next;
          r_a   <= r_a << 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(XLEN - 1)) begin
            r_state      <= S_DONE;
            r_out_valid  <= 1'b1;
            r_mul_result <= w_acc_next;
          end
        end
`endif
        S_DONE: begin
          // in_ready stays low here, so a request present alongside out_ready waits for IDLE
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign illegal     = r_illegal;
  assign control_out = CTRL_W'(r_ctrl);

endmodule

// File: tb/tb_alu_seq_control.sv
// Scoreboard bench for alu_seq_control; the MUL scenarios build only with ALU_SEQ_MULDIV_EN.
module tb_alu_seq_control;
  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      alu_op;
  logic [6:0]      fun7;
  logic [2:0]      fun3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      control_out;
  logic [XLEN-1:0] mul_result;
  logic            illegal;

  int checks;
  int errors;

  typedef struct {
    logic [3:0]      ctrl;
    logic            ill;
    logic [XLEN-1:0] mul;
    int              lat;
  } exp_t;

  exp_t sb[$];

  alu_seq_control #(.XLEN(XLEN), .CTRL_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op     (alu_op),
    .fun7       (fun7),
    .fun3       (fun3),
    .op_a       (op_a),
    .op_b       (op_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .control_out(control_out),
    .mul_result (mul_result),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [1:0] aop, input logic [6:0] f7,
                                 input logic [2:0] f3, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b);
    exp_t e;
    e.ctrl = 4'b1111;
    e.ill  = 1'b1;
    e.mul  = '0;
    e.lat  = 1;
    if (aop == 2'b00) begin
      e.ctrl = 4'b0010; e.ill = 1'b0;
    end else if (aop == 2'b01) begin
      e.ctrl = 4'b0110; e.ill = 1'b0;
    end else if (aop == 2'b10 && f7 == 7'h00) begin
      e.ill = 1'b0;
      case (f3)
        3'd0: e.ctrl = 4'b0010;
        3'd1: e.ctrl = 4'b0011;
        3'd2: e.ctrl = 4'b0100;
        3'd3: e.ctrl = 4'b0101;
        3'd4: e.ctrl = 4'b0111;
        3'd5: e.ctrl = 4'b1000;
        3'd6: e.ctrl = 4'b0001;
        default: e.ctrl = 4'b0000;
      endcase
    end else if (aop == 2'b10 && f7 == 7'h20 && f3 == 3'd0) begin
      e.ctrl = 4'b0110; e.ill = 1'b0;
    end else if (aop == 2'b10 && f7 == 7'h20 && f3 == 3'd5) begin
      e.ctrl = 4'b1001; e.ill = 1'b0;
    end
`ifdef ALU_SEQ_MULDIV_EN
    else if (aop == 2'b10 && f7 == 7'h01 && f3 == 3'd0) begin
      e.ctrl = 4'b1010; e.ill = 1'b0;
      e.mul  = a * b;
      e.lat  = XLEN + 1;
    end
`endif
    return e;
  endfunction

  // Drives one request, then counts rising edges from the transfer edge until out_valid.
  task automatic do_transfer(input logic [1:0] aop, input logic [6:0] f7, input logic [2:0] f3,
                             input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                             output logic [3:0] c, output logic il,
                             output logic [XLEN-1:0] m, output int lat);
    @(negedge clk);
    alu_op = aop; fun7 = f7; fun3 = f3; op_a = a; op_b = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    c = control_out; il = illegal; m = mul_result;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = 2'b00; fun7 = 7'h00; fun3 = 3'd0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (control_out !== 4'b0000) begin errors++; $display("FAIL rst_control got %b exp 0000", control_out); end
    checks++; if (mul_result !== '0) begin errors++; $display("FAIL rst_mul got %h exp 0", mul_result); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal got %b exp 0", illegal); end
    // Release and present AND so the first edge with rst_n high is the transfer edge
    rst_n = 1'b1;
    alu_op = 2'b10; fun7 = 7'h00; fun3 = 3'd7; in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_out_valid got %b exp 1", out_valid); end
    checks++; if (control_out !== 4'b0000) begin errors++; $display("FAIL first_control got %b exp 0000", control_out); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL first_illegal got %b exp 0", illegal); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL first_in_ready got %b exp 0", in_ready); end
    $display("txn first AND ctrl=%b ill=%b", control_out, illegal);
    release_out();
  endtask

  task automatic test_decode();
    logic [6:0] f7_list [4];
    logic [3:0] c;
    logic il;
    logic [XLEN-1:0] m, a, b;
    int lat;
    exp_t e;
    f7_list[0] = 7'h00; f7_list[1] = 7'h20; f7_list[2] = 7'h01; f7_list[3] = 7'h7F;
    for (int aop = 0; aop < 4; aop++) begin
      for (int fi = 0; fi < 4; fi++) begin
        for (int f3 = 0; f3 < 8; f3++) begin
          a = $urandom; b = $urandom;
          sb.push_back(model(2'(aop), f7_list[fi], 3'(f3), a, b));
          do_transfer(2'(aop), f7_list[fi], 3'(f3), a, b, c, il, m, lat);
          e = sb.pop_front();
          $display("txn dec aop=%0d f7=%h f3=%0d ctrl=%b ill=%b lat=%0d", aop, f7_list[fi], f3, c, il, lat);
          checks++; if (c !== e.ctrl) begin errors++; $display("FAIL dec_ctrl aop=%0d f7=%h f3=%0d got %b exp %b", aop, f7_list[fi], f3, c, e.ctrl); end
          checks++; if (il !== e.ill) begin errors++; $display("FAIL dec_illegal aop=%0d f7=%h f3=%0d got %b exp %b", aop, f7_list[fi], f3, il, e.ill); end
          checks++; if (m !== e.mul) begin errors++; $display("FAIL dec_mul aop=%0d f7=%h f3=%0d got %h exp %h", aop, f7_list[fi], f3, m, e.mul); end
          checks++; if (lat != e.lat) begin errors++; $display("FAIL dec_latency aop=%0d f7=%h f3=%0d got %0d exp %0d", aop, f7_list[fi], f3, lat, e.lat); end
          release_out();
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [3:0] c;
    logic il;
    logic [XLEN-1:0] m;
    int lat;
    do_transfer(2'b10, 7'h00, 3'd4, '0, '0, c, il, m, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid cyc=%0d got %b exp 1", i, out_valid); end
      checks++; if (control_out !== 4'b0111) begin errors++; $display("FAIL stall_ctrl cyc=%0d got %b exp 0111", i, control_out); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc=%0d got %b exp 0", i, in_ready); end
    end
    release_out();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_release_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b exp 1", in_ready); end
    $display("txn stall XOR released ready=%b", in_ready);
  endtask

  task automatic test_back_to_back();
    logic [3:0] c;
    logic il;
    logic [XLEN-1:0] m;
    int lat;
    do_transfer(2'b10, 7'h00, 3'd6, '0, '0, c, il, m, lat);
    checks++; if (c !== 4'b0001) begin errors++; $display("FAIL b2b_first_ctrl got %b exp 0001", c); end
    alu_op = 2'b00; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_accept got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle_ready got %b exp 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_second_valid got %b exp 1", out_valid); end
    checks++; if (control_out !== 4'b0010) begin errors++; $display("FAIL b2b_second_ctrl got %b exp 0010", control_out); end
    $display("txn b2b second ctrl=%b", control_out);
    release_out();
  endtask

`ifdef ALU_SEQ_MULDIV_EN
  task automatic test_mul();
    logic [XLEN-1:0] va [7];
    logic [XLEN-1:0] vb [7];
    logic [3:0] c;
    logic il;
    logic [XLEN-1:0] m;
    int lat;
    exp_t e;
    va[0] = 32'h0001_0003; vb[0] = 32'h0000_0005;
    va[1] = 32'h0000_0000; vb[1] = 32'hDEAD_BEEF;
    va[2] = 32'hFFFF_FFFF; vb[2] = 32'h0000_0000;
    va[3] = 32'h8000_0000; vb[3] = 32'h0000_0003;
    va[4] = 32'h1234_5678; vb[4] = 32'h8000_0001;
    va[5] = $urandom;      vb[5] = $urandom;
    va[6] = $urandom;      vb[6] = $urandom;
    for (int i = 0; i < 7; i++) begin
      sb.push_back(model(2'b10, 7'h01, 3'd0, va[i], vb[i]));
      do_transfer(2'b10, 7'h01, 3'd0, va[i], vb[i], c, il, m, lat);
      e = sb.pop_front();
      $display("txn mul a=%h b=%h res=%h lat=%0d", va[i], vb[i], m, lat);
      checks++; if (m !== e.mul) begin errors++; $display("FAIL mul_result i=%0d got %h exp %h", i, m, e.mul); end
      checks++; if (c !== 4'b1010) begin errors++; $display("FAIL mul_ctrl i=%0d got %b exp 1010", i, c); end
      checks++; if (lat != XLEN + 1) begin errors++; $display("FAIL mul_latency i=%0d got %0d exp %0d", i, lat, XLEN + 1); end
      release_out();
    end
  endtask

  task automatic test_mul_hold();
    int lat;
    @(negedge clk);
    alu_op = 2'b10; fun7 = 7'h01; fun3 = 3'd0;
    op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; in_valid = 1'b1;
    @(negedge clk);
    alu_op = 2'b00; op_a = 32'h5; op_b = 32'h7;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    $display("txn mul_hold res=%h ctrl=%b lat=%0d", mul_result, control_out, lat);
    checks++; if (mul_result !== 32'h0000_0001) begin errors++; $display("FAIL hold_mul got %h exp 00000001", mul_result); end
    checks++; if (control_out !== 4'b1010) begin errors++; $display("FAIL hold_ctrl got %b exp 1010", control_out); end
    checks++; if (lat != XLEN + 1) begin errors++; $display("FAIL hold_latency got %0d exp %0d", lat, XLEN + 1); end
    release_out();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_no_accept got %b exp 0", out_valid); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (control_out !== 4'b0010) begin errors++; $display("FAIL hold_next_ctrl got %b exp 0010", control_out); end
    checks++; if (mul_result !== '0) begin errors++; $display("FAIL hold_next_mul got %h exp 0", mul_result); end
    release_out();
  endtask
`endif

  task automatic test_reset_mid();
    logic [3:0] c;
    logic il;
    logic [XLEN-1:0] m;
    int lat;
    exp_t e;
`ifdef ALU_SEQ_MULDIV_EN
    @(negedge clk);
    alu_op = 2'b10; fun7 = 7'h01; fun3 = 3'd0; op_a = 32'h3; op_b = 32'h7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midmul_valid got %b exp 0", out_valid); end
    checks++; if (control_out !== 4'b0000) begin errors++; $display("FAIL midmul_ctrl got %b exp 0000", control_out); end
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
`endif
    do_transfer(2'b01, 7'h00, 3'd0, '0, '0, c, il, m, lat);
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL middone_valid got %b exp 0", out_valid); end
    checks++; if (control_out !== 4'b0000) begin errors++; $display("FAIL middone_ctrl got %b exp 0000", control_out); end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b exp 1", in_ready); end
    sb.push_back(model(2'b00, 7'h00, 3'd0, '0, '0));
    do_transfer(2'b00, 7'h00, 3'd0, '0, '0, c, il, m, lat);
    e = sb.pop_front();
    $display("txn post_reset ADD ctrl=%b lat=%0d", c, lat);
    checks++; if (c !== e.ctrl) begin errors++; $display("FAIL postrst_ctrl got %b exp %b", c, e.ctrl); end
    checks++; if (lat != e.lat) begin errors++; $display("FAIL postrst_latency got %0d exp %0d", lat, e.lat); end
    release_out();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_decode();
    test_stall();
    test_back_to_back();
`ifdef ALU_SEQ_MULDIV_EN
    test_mul();
    test_mul_hold();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
